// File: rtl/store_commit_buffer_pkg.sv
// Shared types and constants for the post-retirement store commit buffer.
// Optional forwarding logic in the top is enabled by defining STORE_FWD_EN.
package store_commit_buffer_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_STRB_W = SB_DATA_W / 8;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [2:0]           funct3;
    } RETIRE_STORE_t;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_STRB_W-1:0] strb;
    } SB_ENTRY_t;

endpackage

// File: rtl/store_align.sv
// Combinational store lane alignment: replicates the store data across lanes
// and builds the byte strobe from the low address bits and funct3.
module store_align
    import store_commit_buffer_pkg::*;
(
    input  logic [1:0]           offset_i,
    input  logic [SB_DATA_W-1:0] data_i,
    input  logic [2:0]           funct3_i,
    output logic [SB_DATA_W-1:0] data_o,
    output logic [SB_STRB_W-1:0] strb_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        data_o = data_i;
        strb_o = '0;
        case (funct3_i)
            F3_SB: begin
                data_o = {SB_STRB_W{data_i[7:0]}};
                strb_o = 4'b0001 << offset_i;
            end
            F3_SH: begin
                data_o = {(SB_DATA_W/16){data_i[15:0]}};
                strb_o = 4'b0011 << {offset_i[1], 1'b0};
            end
            F3_SW: begin
                strb_o = '1;
            end
            default: begin
                // Unsupported size: enqueued as a no-op write with no bytes enabled.
                strb_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/store_commit_buffer.sv
// In-order FIFO of committed stores draining to data memory via valid/ready.
// Define STORE_FWD_EN to build the store-to-load forwarding compare.
module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = SB_ADDR_W,
    parameter int DATA_WIDTH = SB_DATA_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  RETIRE_STORE_t           retire_store_pkg,
    output logic                    sb_full,
    output logic                    sb_empty,
    output logic                    overflow_err,
    output logic                    mem_req_valid,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [DATA_WIDTH/8-1:0] mem_req_strb,
    input  logic                    mem_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    output logic                    fwd_hit,
    output logic [DATA_WIDTH-1:0]   fwd_data,
    output logic [DATA_WIDTH/8-1:0] fwd_strb
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] count;
    logic             enq, deq;
    SB_ENTRY_t        mem_q [FIFO_DEPTH];
    SB_ENTRY_t        new_entry;
    SB_ENTRY_t        head;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign sb_full  = (count == PTR_W'(FIFO_DEPTH));
    assign sb_empty = (count == '0);

    // A store arriving while full is dropped even if the head drains this cycle.
    assign enq = retire_store_pkg.valid && !sb_full;
    assign deq = !sb_empty && mem_req_ready;

    store_align u_align (
        .offset_i (retire_store_pkg.addr[1:0]),
        .data_i   (retire_store_pkg.data),
        .funct3_i (retire_store_pkg.funct3),
        .data_o   (new_entry.data),
        .strb_o   (new_entry.strb)
    );

    assign new_entry.addr = {retire_store_pkg.addr[SB_ADDR_W-1:2], 2'b00};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        if (retire_store_pkg.valid && sb_full) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the entry array is deliberately not reset; every read of it is
    // qualified by occupancy, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q[IDX_W-1:0]] <= new_entry;
    end

    assign overflow_err  = overflow_q;
    assign head          = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign mem_req_valid = !sb_empty;
    assign mem_req_addr  = mem_req_valid ? head.addr : '0;
    assign mem_req_data  = mem_req_valid ? head.data : '0;
    assign mem_req_strb  = mem_req_valid ? head.strb : '0;

`ifdef STORE_FWD_EN
    logic [IDX_W-1:0] fwd_idx;
    logic             unused_ld_lo;

    assign unused_ld_lo = ^ld_addr[1:0];

    // Walk oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_strb = '0;
        fwd_idx  = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            fwd_idx = rd_ptr_q[IDX_W-1:0] + IDX_W'(k);
            if ((PTR_W'(k) < count) &&
                (mem_q[fwd_idx].addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_q[fwd_idx].data;
                fwd_strb = mem_q[fwd_idx].strb;
            end
        end
    end
`else
    logic unused_ld;

    assign unused_ld = ^ld_addr;
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
    assign fwd_strb  = '0;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Scoreboard bench for store_commit_buffer: stimulus pushes expected memory
// requests, an independent monitor pops and compares on each handshake.
module tb_store_commit_buffer;
    import store_commit_buffer_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    RETIRE_STORE_t rs;
    logic          sb_full, sb_empty, overflow_err;
    logic          mem_req_valid, mem_req_ready;
    logic [31:0]   mem_req_addr, mem_req_data;
    logic [3:0]    mem_req_strb;
    logic [31:0]   ld_addr;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [3:0]    fwd_strb;

    SB_ENTRY_t exp_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    store_commit_buffer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .retire_store_pkg (rs),
        .sb_full          (sb_full),
        .sb_empty         (sb_empty),
        .overflow_err     (overflow_err),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_data     (mem_req_data),
        .mem_req_strb     (mem_req_strb),
        .mem_req_ready    (mem_req_ready),
        .ld_addr          (ld_addr),
        .fwd_hit          (fwd_hit),
        .fwd_data         (fwd_data),
        .fwd_strb         (fwd_strb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the head against the scoreboard on every handshake.
    initial begin
        SB_ENTRY_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid && mem_req_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req_valid", 64'(mem_req_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("req_addr", 64'(mem_req_addr), 64'(e.addr));
                    check("req_strb", 64'(mem_req_strb), 64'(e.strb));
                    if (e.strb != '0) check("req_data", 64'(mem_req_data), 64'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es,
                        input bit push);
        rs.valid  = 1'b1;
        rs.funct3 = f3;
        rs.addr   = a;
        rs.data   = d;
        if (push) exp_q.push_back('{addr: ea, data: ed, strb: es});
        tick();
        rs.valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        mem_req_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        mem_req_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, 64'(sb_empty), 64'd1);
        check({tag, "_full"}, 64'(sb_full), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_err), 64'd0);
        check({tag, "_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_addr"}, 64'(mem_req_addr), 64'd0);
        check({tag, "_data"}, 64'(mem_req_data), 64'd0);
        check({tag, "_strb"}, 64'(mem_req_strb), 64'd0);
        check({tag, "_fwd_hit"}, 64'(fwd_hit), 64'd0);
        check({tag, "_fwd_data"}, 64'(fwd_data), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        rs            = '0;
        mem_req_ready = 1'b0;
        ld_addr       = 32'h0;
        rst_n         = 1'b0;
        #13;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        tick();

        // Single SW: one-cycle latency, empty again after the handshake.
        mem_req_ready = 1'b1;
        send(F3_SW, 32'h1000, 32'hDEADBEEF, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b1);
        check("sw_latency_valid", 64'(mem_req_valid), 64'd1);
        check("sw_not_empty", 64'(sb_empty), 64'd0);
        tick();
        check("sw_empty_after", 64'(sb_empty), 64'd1);
        mem_req_ready = 1'b0;

        // Byte/halfword alignment and an unsupported funct3.
        send(F3_SB, 32'h2003, 32'h000000AB, 32'h2000, 32'hABABABAB, 4'b1000, 1'b1);
        send(F3_SH, 32'h2002, 32'h00001234, 32'h2000, 32'h12341234, 4'b1100, 1'b1);
        send(F3_SB, 32'h2000, 32'h000001CD, 32'h2000, 32'hCDCDCDCD, 4'b0001, 1'b1);
        send(3'b011, 32'h2004, 32'h00000055, 32'h2004, 32'h00000055, 4'b0000, 1'b1);
        tick();
        check("hold_addr", 64'(mem_req_addr), 64'h2000);
        check("hold_strb", 64'(mem_req_strb), 64'h8);
        check("hold_data", 64'(mem_req_data), 64'hABABABAB);
        wait_drain(20);

        // Forwarding: youngest matching word wins.
        send(F3_SW, 32'h3000, 32'h11111111, 32'h3000, 32'h11111111, 4'hF, 1'b1);
        ld_addr = 32'h3002;
        #1;
`ifdef STORE_FWD_EN
        check("fwd1_hit", 64'(fwd_hit), 64'd1);
        check("fwd1_data", 64'(fwd_data), 64'h11111111);
        check("fwd1_strb", 64'(fwd_strb), 64'hF);
`else
        check("fwd1_hit_off", 64'(fwd_hit), 64'd0);
`endif
        send(F3_SB, 32'h3001, 32'h00000022, 32'h3000, 32'h22222222, 4'b0010, 1'b1);
        #1;
`ifdef STORE_FWD_EN
        check("fwd2_hit", 64'(fwd_hit), 64'd1);
        check("fwd2_data", 64'(fwd_data), 64'h22222222);
        check("fwd2_strb", 64'(fwd_strb), 64'b0010);
`else
        check("fwd2_hit_off", 64'(fwd_hit), 64'd0);
        check("fwd2_data_off", 64'(fwd_data), 64'd0);
        check("fwd2_strb_off", 64'(fwd_strb), 64'd0);
`endif
        ld_addr = 32'h3004;
        #1;
        check("fwd_miss_hit", 64'(fwd_hit), 64'd0);
        wait_drain(20);

        // Fill to full, then drop an enqueue that coincides with a dequeue.
        for (int i = 0; i < 16; i++)
            send(F3_SW, 32'h4000 + 32'(4 * i), 32'hA5000000 + 32'(i),
                 32'h4000 + 32'(4 * i), 32'hA5000000 + 32'(i), 4'hF, 1'b1);
        check("fill_full", 64'(sb_full), 64'd1);
        check("fill_ovf_clear", 64'(overflow_err), 64'd0);
        mem_req_ready = 1'b1;
        send(F3_SW, 32'h4FFC, 32'hBADBAD00, 32'h0, 32'h0, 4'h0, 1'b0);
        mem_req_ready = 1'b0;
        check("drop_ovf_set", 64'(overflow_err), 64'd1);
        check("drop_full_after_deq", 64'(sb_full), 64'd0);
        wait_drain(64);
        check("drain_empty", 64'(sb_empty), 64'd1);
        check("ovf_sticky", 64'(overflow_err), 64'd1);

        // Wrap-around with random ready.
        for (int i = 0; i < 40; i++) begin
            guard = 0;
            while (sb_full && guard < 100) begin
                mem_req_ready = 1'b1;
                tick();
                guard++;
            end
            mem_req_ready = 1'($urandom_range(0, 1));
            send(F3_SW, 32'h5000 + 32'(4 * i), 32'h0BAD0000 + 32'(i * 257),
                 32'h5000 + 32'(4 * i), 32'h0BAD0000 + 32'(i * 257), 4'hF, 1'b1);
        end
        wait_drain(200);

        // Reset mid-drain discards all entries immediately.
        for (int i = 0; i < 5; i++)
            send(F3_SW, 32'h6000 + 32'(4 * i), 32'h66000000 + 32'(i),
                 32'h6000 + 32'(4 * i), 32'h66000000 + 32'(i), 4'hF, 1'b1);
        check("pre_reset_valid", 64'(mem_req_valid), 64'd1);
        ld_addr = 32'h6000;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        tick();
        rst_n         = 1'b1;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_reset_valid", 64'(mem_req_valid), 64'd0);
        check("post_reset_empty", 64'(sb_empty), 64'd1);
        mem_req_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
